// File: rtl/mipi_lp_hs_lane_tx_if.sv
// Byte-stream handshake between the payload source and the lane transmitter.
// The master drives payload bytes; the slave (the lane) answers with ready.
interface mipi_lp_hs_lane_tx_if;
    logic [7:0] byte_data_i;
    logic       byte_valid_i;
    logic       byte_last_i;
    logic       byte_ready_o;

    modport master (
        output byte_data_i,
        output byte_valid_i,
        output byte_last_i,
        input  byte_ready_o
    );

    modport slave (
        input  byte_data_i,
        input  byte_valid_i,
        input  byte_last_i,
        output byte_ready_o
    );
endinterface

// File: rtl/mipi_lp_hs_lane_tx.sv
// MIPI D-PHY data lane transmit sequencer: LP stop/request/prepare, HS zero,
// sync, payload, trail and exit, driving LP line state and an HS byte stream.
module mipi_lp_hs_lane_tx #(
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 3,
    parameter int T_HS_ZERO    = 5,
    parameter int T_HS_TRAIL   = 4,
    parameter int T_HS_EXIT    = 6
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         burst_req_i,
    mipi_lp_hs_lane_tx_if.slave          byte_if,
    output logic [1:0]                   lp_lane_data0_o,
    output logic                         hs_en_o,
    output logic [7:0]                   hs_byte_o,
    output logic                         busy_o,
    output logic                         underflow_o
);

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // Counters hold remaining cycles minus one; a zero parameter acts as one.
    localparam logic [7:0] L_LPX  = (T_LPX        < 2) ? 8'd0 : 8'(T_LPX - 1);
    localparam logic [7:0] L_PRPR = (T_HS_PREPARE < 2) ? 8'd0 : 8'(T_HS_PREPARE - 1);
    localparam logic [7:0] L_ZERO = (T_HS_ZERO    < 2) ? 8'd0 : 8'(T_HS_ZERO - 1);
    localparam logic [7:0] L_TRL  = (T_HS_TRAIL   < 2) ? 8'd0 : 8'(T_HS_TRAIL - 1);
    localparam logic [7:0] L_EXIT = (T_HS_EXIT    < 2) ? 8'd0 : 8'(T_HS_EXIT - 1);
    // After an underflow cycle one trail cycle is already spent; keep at least one.
    localparam logic [7:0] L_TRL_UF = (T_HS_TRAIL < 3) ? 8'd0 : 8'(T_HS_TRAIL - 2);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_RQST,
        ST_PRPR,
        ST_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_EXIT
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] trail_byte;
    logic       uf_q;
    logic       cnt_done;

    assign cnt_done    = (cnt == 8'd0);
    assign underflow_o = uf_q;

    // Sequencer: state, per-state duration counter, trail byte and sticky underflow.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= ST_STOP;
            cnt        <= 8'd0;
            trail_byte <= SYNC_BYTE;
            uf_q       <= 1'b0;
        end else begin
            unique case (state)
                ST_STOP: begin
                    if (burst_req_i) begin
                        state      <= ST_RQST;
                        cnt        <= L_LPX;
                        trail_byte <= SYNC_BYTE;
                        uf_q       <= 1'b0;
                    end
                end
                ST_RQST: begin
                    if (cnt_done) begin
                        state <= ST_PRPR;
                        cnt   <= L_PRPR;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_PRPR: begin
                    if (cnt_done) begin
                        state <= ST_ZERO;
                        cnt   <= L_ZERO;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_ZERO: begin
                    if (cnt_done) begin
                        state <= ST_SYNC;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_SYNC: begin
                    state <= ST_DATA;
                    cnt   <= 8'd0;
                end
                ST_DATA: begin
                    if (byte_if.byte_valid_i) begin
                        trail_byte <= {8{~byte_if.byte_data_i[7]}};
                        if (byte_if.byte_last_i) begin
                            state <= ST_TRAIL;
                            cnt   <= L_TRL;
                        end
                    end else begin
                        uf_q  <= 1'b1;
                        state <= ST_TRAIL;
                        cnt   <= L_TRL_UF;
                    end
                end
                ST_TRAIL: begin
                    if (cnt_done) begin
                        state <= ST_EXIT;
                        cnt   <= L_EXIT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_EXIT: begin
                    if (cnt_done) begin
                        state <= ST_STOP;
                        cnt   <= 8'd0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    // Line and HS outputs decoded from the state; payload passes straight through in DATA.
    always_comb begin
        lp_lane_data0_o      = 2'b00;
        hs_en_o              = 1'b0;
        hs_byte_o            = 8'h00;
        byte_if.byte_ready_o = 1'b0;
        busy_o               = 1'b1;
        unique case (state)
            ST_STOP: begin
                lp_lane_data0_o = 2'b11;
                busy_o          = 1'b0;
            end
            ST_RQST: begin
                lp_lane_data0_o = 2'b01;
            end
            ST_PRPR: begin
                hs_en_o = 1'b0;
            end
            ST_ZERO: begin
                hs_en_o = 1'b1;
            end
            ST_SYNC: begin
                hs_en_o   = 1'b1;
                hs_byte_o = SYNC_BYTE;
            end
            ST_DATA: begin
                hs_en_o              = 1'b1;
                byte_if.byte_ready_o = 1'b1;
                hs_byte_o            = byte_if.byte_valid_i ?
                                       byte_if.byte_data_i : trail_byte;
            end
            ST_TRAIL: begin
                hs_en_o   = 1'b1;
                hs_byte_o = trail_byte;
            end
            ST_EXIT: begin
                lp_lane_data0_o = 2'b11;
            end
        endcase
    end

endmodule
